// File: rtl/pci_init_pkg.sv
// Shared types and constants for the PCI initiator command sequencer.
package pci_init_pkg;

  localparam int unsigned ADDR_W = 30;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned CSR_W  = 40;

  localparam int unsigned CSR_FATAL0 = 38;
  localparam int unsigned CSR_FATAL1 = 39;
  localparam int unsigned CSR_RETRY  = 36;

  localparam logic [3:0] CMD_MEM_RD = 4'b0110;
  localparam logic [3:0] CMD_MEM_WR = 4'b0111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_XFER,
    ST_RTY,
    ST_DONE,
    ST_DEAD
  } state_e;

  typedef enum logic [1:0] {
    ERR_OK    = 2'b00,
    ERR_RETRY = 2'b01,
    ERR_FATAL = 2'b10
  } rsp_err_e;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

endpackage

// File: rtl/pci_init_term_decode.sv
// Detects the end of a core data phase and captures the termination status
// (fatal / retry) seen while the data phase was active.
module pci_init_term_decode
  import pci_init_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             m_data,
  input  logic             m_addr_n,
  input  logic [CSR_W-1:0] csr,
  output logic             fell,
  output logic             fatal,
  output logic             retry
);

  logic m_data_q, m_data_d;
  logic fatal_q, fatal_d;
  logic retry_q, retry_d;
  logic unused_csr;

  assign unused_csr = ^{csr[37], csr[35:0]};

  // A new address phase clears stale status; an active data phase reloads it.
  always_comb begin
    m_data_d = m_data;
    fatal_d  = fatal_q;
    retry_d  = retry_q;
    if (!m_addr_n) begin
      fatal_d = 1'b0;
      retry_d = 1'b0;
    end else if (m_data) begin
      fatal_d = csr[CSR_FATAL1] | csr[CSR_FATAL0];
      retry_d = csr[CSR_RETRY];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_data_q <= 1'b0;
      fatal_q  <= 1'b0;
      retry_q  <= 1'b0;
    end else begin
      m_data_q <= m_data_d;
      fatal_q  <= fatal_d;
      retry_q  <= retry_d;
    end
  end

  assign fell  = ~m_data & m_data_q;
  assign fatal = fatal_q;
  assign retry = retry_q;

endmodule

// File: rtl/pci_init_cmd_seq.sv
// Single-dword PCI initiator sequencer between user command logic and the PCI core.
// Define PCI_INIT_RETRY_LIMIT_EN to abort a command after MAX_RETRY retries.
module pci_init_cmd_seq
  import pci_init_pkg::*;
#(
  parameter int unsigned MAX_RETRY = 15,
  parameter int unsigned RCNT_W    = 4
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [BE_W-1:0]   cmd_be,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_err,
  input  logic [DATA_W-1:0] adio_out,
  output logic [DATA_W-1:0] adio_in,
  output logic              adio_in_oe,
  input  logic              m_data,
  input  logic              m_data_vld,
  input  logic              m_addr_n,
  input  logic [CSR_W-1:0]  csr,
  output logic              request,
  output logic              requesthold,
  output logic              complete,
  output logic              m_ready,
  output logic [3:0]        m_cbe,
  output logic              m_wrdn
);

  localparam logic [RCNT_W-1:0] RETRY_LIMIT = RCNT_W'(MAX_RETRY);

  state_e              state_q, state_d;
  cmd_t                cmd_q, cmd_d;
  logic [RCNT_W-1:0]   rcnt_q, rcnt_d;
  logic                captured_q, captured_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  rsp_err_e            err_q, err_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                request_q, request_d;
  logic                complete_q, complete_d;
  logic                m_ready_q;
  logic                fell, fatal, retry;

  pci_init_term_decode u_term (
    .clk      (CLK),
    .rst      (reset),
    .m_data   (m_data),
    .m_addr_n (m_addr_n),
    .csr      (csr),
    .fell     (fell),
    .fatal    (fatal),
    .retry    (retry)
  );

`ifndef PCI_INIT_RETRY_LIMIT_EN
  logic unused_limit;
  assign unused_limit = ^RETRY_LIMIT;
`endif

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    rcnt_d      = rcnt_q;
    captured_d  = captured_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    rsp_valid_d = rsp_valid_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          cmd_d   = '{wr: cmd_wr, addr: cmd_addr, be: cmd_be, wdata: cmd_wdata};
          rcnt_d  = '0;
          rdata_d = '0;
          err_d   = ERR_OK;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        captured_d = 1'b0;
        state_d    = ST_XFER;
      end
      ST_XFER: begin
        if (!cmd_q.wr && m_data_vld && !captured_q) begin
          rdata_d    = adio_out;
          captured_d = 1'b1;
        end
        // Fatal termination takes priority over a retry request.
        if (fell) begin
          if (fatal) begin
            state_d     = ST_DEAD;
            rsp_valid_d = 1'b1;
            err_d       = ERR_FATAL;
          end else if (retry) begin
            state_d = ST_RTY;
          end else begin
            state_d     = ST_DONE;
            rsp_valid_d = 1'b1;
            err_d       = ERR_OK;
          end
        end
      end
      ST_RTY: begin
`ifdef PCI_INIT_RETRY_LIMIT_EN
        if (rcnt_q == RETRY_LIMIT) begin
          state_d     = ST_DONE;
          rsp_valid_d = 1'b1;
          err_d       = ERR_RETRY;
        end else begin
          rcnt_d  = rcnt_q + RCNT_W'(1);
          state_d = ST_REQ;
        end
`else
        rcnt_d  = rcnt_q + RCNT_W'(1);
        state_d = ST_REQ;
`endif
      end
      ST_DONE: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      ST_DEAD: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    request_d  = (state_d == ST_REQ);
    complete_d = (state_q == ST_REQ) || (state_q == ST_XFER);
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      rcnt_q      <= '0;
      captured_q  <= 1'b0;
      rdata_q     <= '0;
      err_q       <= ERR_OK;
      rsp_valid_q <= 1'b0;
      request_q   <= 1'b0;
      complete_q  <= 1'b0;
      m_ready_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      rcnt_q      <= rcnt_d;
      captured_q  <= captured_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      request_q   <= request_d;
      complete_q  <= complete_d;
      m_ready_q   <= 1'b1;
    end
  end

  // Address/data drive toward the core, qualified by an active transaction.
  always_comb begin
    m_cbe      = m_addr_n ? ~cmd_q.be : (cmd_q.wr ? CMD_MEM_WR : CMD_MEM_RD);
    adio_in    = '0;
    adio_in_oe = 1'b0;
    if (!m_addr_n && ((state_q == ST_REQ) || (state_q == ST_XFER))) begin
      adio_in    = {cmd_q.addr, 2'b00};
      adio_in_oe = 1'b1;
    end else if ((state_q == ST_XFER) && cmd_q.wr && m_data) begin
      adio_in    = cmd_q.wdata;
      adio_in_oe = 1'b1;
    end
  end

  assign cmd_ready   = (state_q == ST_IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign request     = request_q;
  assign requesthold = 1'b0;
  assign complete    = complete_q;
  assign m_ready     = m_ready_q;
  assign m_wrdn      = cmd_q.wr;

endmodule

// File: tb/tb_pci_init_cmd_seq.sv
// Directed table-driven bench for pci_init_cmd_seq with a simple PCI core model.
module tb_pci_init_cmd_seq;

  logic        CLK;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_wr;
  logic [29:0] cmd_addr;
  logic [3:0]  cmd_be;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic [31:0] adio_out, adio_in;
  logic        adio_in_oe;
  logic        m_data, m_data_vld, m_addr_n;
  logic [39:0] csr;
  logic        request, requesthold, complete, m_ready, m_wrdn;
  logic [3:0]  m_cbe;

  pci_init_cmd_seq #(.MAX_RETRY(2), .RCNT_W(4)) dut (
    .CLK(CLK), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_be(cmd_be), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .adio_out(adio_out), .adio_in(adio_in), .adio_in_oe(adio_in_oe),
    .m_data(m_data), .m_data_vld(m_data_vld), .m_addr_n(m_addr_n), .csr(csr),
    .request(request), .requesthold(requesthold), .complete(complete),
    .m_ready(m_ready), .m_cbe(m_cbe), .m_wrdn(m_wrdn)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int req_cnt = 0;
  always @(posedge CLK) if (request === 1'b1) req_cnt <= req_cnt + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        wr;
    logic [29:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic [31:0] e_adio_addr;
    logic [3:0]  e_cbe_addr;
    logic [3:0]  e_cbe_data;
    logic [31:0] e_adio_data;
    logic        e_oe_data;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs[4];

  logic [31:0] obs_adio_addr, obs_adio_data;
  logic        obs_oe_addr, obs_oe_data, obs_complete, obs_wrdn;
  logic [3:0]  obs_cbe_addr, obs_cbe_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_cmd(input logic wr, input logic [29:0] addr, input logic [3:0] be,
                          input logic [31:0] wdata);
    @(negedge CLK);
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_be = be; cmd_wdata = wdata;
    @(negedge CLK);
    cmd_valid = 1'b0;
  endtask

  // Core model: waits for request, then address phase, two data cycles, end.
  task automatic attempt(input string tag, input logic [31:0] rd, input logic fat, input logic rty);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (request === 1'b1) seen = 1'b1;
      else @(negedge CLK);
    end
    if (!seen) begin
      chk({tag, "_req_timeout"}, 32'd0, 32'd1);
      return;
    end
    @(negedge CLK);
    m_addr_n = 1'b0;
    #1;
    obs_adio_addr = adio_in; obs_oe_addr = adio_in_oe; obs_cbe_addr = m_cbe;
    obs_complete = complete; obs_wrdn = m_wrdn;
    @(negedge CLK);
    m_addr_n = 1'b1; m_data = 1'b1;
    csr = '0; csr[38] = fat; csr[36] = rty;
    #1;
    obs_cbe_data = m_cbe; obs_adio_data = adio_in; obs_oe_data = adio_in_oe;
    @(negedge CLK);
    m_data_vld = 1'b1; adio_out = rd;
    @(negedge CLK);
    m_data_vld = 1'b0; adio_out = '0; m_data = 1'b0; csr = '0;
    @(negedge CLK);
  endtask

  task automatic ack_rsp(input string tag);
    rsp_ready = 1'b1;
    @(negedge CLK);
    rsp_ready = 1'b0;
    chk({tag, "_valid_after_ack"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    int base;
    vecs[0] = '{1'b1, 30'h0400_0010, 4'hF, 32'hDEAD_BEEF, 32'h0,
                32'h1000_0040, 4'b0111, 4'b0000, 32'hDEAD_BEEF, 1'b1, 32'h0};
    vecs[1] = '{1'b0, 30'h0000_0040, 4'hF, 32'h0, 32'h1234_5678,
                32'h0000_0100, 4'b0110, 4'b0000, 32'h0, 1'b0, 32'h1234_5678};
    vecs[2] = '{1'b1, 30'h3FFF_FFFF, 4'b0101, 32'hA5A5_5A5A, 32'hFFFF_FFFF,
                32'hFFFF_FFFC, 4'b0111, 4'b1010, 32'hA5A5_5A5A, 1'b1, 32'h0};
    vecs[3] = '{1'b0, 30'h0000_0000, 4'b1000, 32'hFFFF_FFFF, 32'hCAFE_F00D,
                32'h0000_0000, 4'b0110, 4'b0111, 32'h0, 1'b0, 32'hCAFE_F00D};

    reset = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_be = '0;
    cmd_wdata = '0; rsp_ready = 1'b0; adio_out = '0; m_data = 1'b0;
    m_data_vld = 1'b0; m_addr_n = 1'b1; csr = '0;

    repeat (3) @(negedge CLK);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_m_ready", 32'(m_ready), 32'd0);
    chk("rst_request", 32'(request), 32'd0);
    chk("rst_oe", 32'(adio_in_oe), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    reset = 1'b0;
    @(negedge CLK);
    chk("m_ready_after_rst", 32'(m_ready), 32'd1);
    chk("requesthold", 32'(requesthold), 32'd0);

    // Clean single-attempt transactions from the table.
    for (int i = 0; i < 4; i++) begin
      string t;
      t = $sformatf("v%0d", i);
      base = req_cnt;
      send_cmd(vecs[i].wr, vecs[i].addr, vecs[i].be, vecs[i].wdata);
      chk({t, "_cmd_ready_busy"}, 32'(cmd_ready), 32'd0);
      attempt(t, vecs[i].rd, 1'b0, 1'b0);
      chk({t, "_adio_addr"}, obs_adio_addr, vecs[i].e_adio_addr);
      chk({t, "_oe_addr"}, 32'(obs_oe_addr), 32'd1);
      chk({t, "_cbe_addr"}, 32'(obs_cbe_addr), 32'(vecs[i].e_cbe_addr));
      chk({t, "_complete"}, 32'(obs_complete), 32'd1);
      chk({t, "_wrdn"}, 32'(obs_wrdn), 32'(vecs[i].wr));
      chk({t, "_cbe_data"}, 32'(obs_cbe_data), 32'(vecs[i].e_cbe_data));
      chk({t, "_adio_data"}, obs_adio_data, vecs[i].e_adio_data);
      chk({t, "_oe_data"}, 32'(obs_oe_data), 32'(vecs[i].e_oe_data));
      chk({t, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
      chk({t, "_rsp_err"}, 32'(rsp_err), 32'd0);
      chk({t, "_rsp_rdata"}, rsp_rdata, vecs[i].e_rdata);
      chk({t, "_req_count"}, 32'(req_cnt - base), 32'd1);
      ack_rsp(t);
      chk({t, "_cmd_ready_idle"}, 32'(cmd_ready), 32'd1);
    end

    // Read retried twice then clean; response held without rsp_ready.
    base = req_cnt;
    send_cmd(1'b0, 30'h0000_0080, 4'hF, 32'h0);
    attempt("rty1", 32'h1111_1111, 1'b0, 1'b1);
    chk("rty1_no_rsp", 32'(rsp_valid), 32'd0);
    attempt("rty2", 32'h2222_2222, 1'b0, 1'b1);
    chk("rty2_no_rsp", 32'(rsp_valid), 32'd0);
    attempt("rty3", 32'h3333_3333, 1'b0, 1'b0);
    chk("rty_req_count", 32'(req_cnt - base), 32'd3);
    chk("rty_err", 32'(rsp_err), 32'd0);
    chk("rty_rdata", rsp_rdata, 32'h3333_3333);
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      chk($sformatf("hold%0d_valid", k), 32'(rsp_valid), 32'd1);
      chk($sformatf("hold%0d_rdata", k), rsp_rdata, 32'h3333_3333);
    end
    chk("hold_req_count", 32'(req_cnt - base), 32'd3);
    ack_rsp("rty");

    // Retry status stuck on every attempt.
    base = req_cnt;
    send_cmd(1'b0, 30'h0000_00C0, 4'hF, 32'h0);
    for (int k = 0; k < 3; k++) attempt($sformatf("stk%0d", k), 32'h0, 1'b0, 1'b1);
    chk("stk_req_count3", 32'(req_cnt - base), 32'd3);
`ifdef PCI_INIT_RETRY_LIMIT_EN
    begin
      bit got = 1'b0;
      for (int k = 0; k < 10 && !got; k++) begin
        if (rsp_valid === 1'b1) got = 1'b1;
        else @(negedge CLK);
      end
      chk("lim_rsp_valid", 32'(got), 32'd1);
      chk("lim_rsp_err", 32'(rsp_err), 32'd1);
      repeat (3) @(negedge CLK);
      chk("lim_req_count", 32'(req_cnt - base), 32'd3);
      ack_rsp("lim");
    end
`else
    attempt("stk3", 32'h0, 1'b0, 1'b1);
    attempt("stk4", 32'h0, 1'b0, 1'b1);
    chk("stk_req_count5", 32'(req_cnt - base), 32'd5);
    chk("stk_no_rsp", 32'(rsp_valid), 32'd0);
    attempt("stk5", 32'h5555_AAAA, 1'b0, 1'b0);
    chk("stk_final_valid", 32'(rsp_valid), 32'd1);
    chk("stk_final_err", 32'(rsp_err), 32'd0);
    chk("stk_final_rdata", rsp_rdata, 32'h5555_AAAA);
    ack_rsp("stk");
`endif
    chk("stk_idle", 32'(cmd_ready), 32'd1);

    // Fatal termination: sticky dead state until reset.
    send_cmd(1'b1, 30'h0000_0100, 4'hF, 32'h0BAD_F00D);
    attempt("fat", 32'h0, 1'b1, 1'b1);
    chk("fat_valid", 32'(rsp_valid), 32'd1);
    chk("fat_err", 32'(rsp_err), 32'd2);
    ack_rsp("fat");
    base = req_cnt;
    cmd_valid = 1'b1;
    repeat (4) @(negedge CLK);
    cmd_valid = 1'b0;
    chk("dead_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("dead_no_req", 32'(req_cnt - base), 32'd0);
    chk("dead_valid", 32'(rsp_valid), 32'd0);
    reset = 1'b1;
    #1;
    chk("dead_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge CLK);
    reset = 1'b0;
    @(negedge CLK);

    // Reset asserted mid-transfer during the address phase.
    send_cmd(1'b0, 30'h0000_0200, 4'hF, 32'h0);
    begin
      bit seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
        if (request === 1'b1) seen = 1'b1;
        else @(negedge CLK);
      end
      chk("mid_req_seen", 32'(seen), 32'd1);
    end
    @(negedge CLK);
    m_addr_n = 1'b0;
    #1;
    chk("mid_oe_before", 32'(adio_in_oe), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("mid_oe", 32'(adio_in_oe), 32'd0);
    chk("mid_adio", adio_in, 32'd0);
    chk("mid_complete", 32'(complete), 32'd0);
    chk("mid_m_ready", 32'(m_ready), 32'd0);
    chk("mid_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("mid_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge CLK);
    m_addr_n = 1'b1;
    reset = 1'b0;
    repeat (4) @(negedge CLK);
    chk("mid_after_no_rsp", 32'(rsp_valid), 32'd0);
    chk("mid_after_idle", 32'(cmd_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
